// File: rtl/lut_table_loader.sv
// Streams a 2^IN_BITS-entry lookup table in, then serves 1-cycle registered lookups.
// Define LUT_CHECKSUM_EN to add the load_sum running checksum output.
module lut_table_loader #(
  parameter int IN_BITS  = 8,
  parameter int OUT_BITS = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_start,
  input  logic                wr_valid,
  input  logic [OUT_BITS-1:0] wr_data,
  output logic                wr_ready,
  output logic                load_done,
  output logic                table_ok,
  input  logic [IN_BITS-1:0]  M0,
  input  logic                M0_valid,
  output logic [OUT_BITS-1:0] M1,
  output logic                M1_valid
`ifdef LUT_CHECKSUM_EN
  ,
  output logic [15:0]         load_sum
`endif
);

  localparam int DEPTH = 1 << IN_BITS;

  // IDLE: no valid table | LOAD: accepting entries | SERVE: table complete, lookups served
  typedef enum logic [1:0] {IDLE, LOAD, SERVE} state_t;

  state_t              state_q, state_d;
  logic [IN_BITS-1:0]  wr_addr_q, wr_addr_d;
  logic                load_done_q, load_done_d;
  logic [OUT_BITS-1:0] m1_q;
  logic                m1_valid_q;
  logic                wr_fire;
  logic                lookup;
  logic [OUT_BITS-1:0] table_q [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      wr_addr_q   <= '0;
      load_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_addr_q   <= wr_addr_d;
      load_done_q <= load_done_d;
    end
  end

  // A restart in LOAD discards any transfer offered in the same cycle.
  always_comb begin
    state_d     = state_q;
    wr_addr_d   = wr_addr_q;
    load_done_d = 1'b0;
    wr_fire     = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_start) begin
          state_d   = LOAD;
          wr_addr_d = '0;
        end
      end
      LOAD: begin
        if (load_start) begin
          wr_addr_d = '0;
        end else if (wr_valid) begin
          wr_fire   = 1'b1;
          wr_addr_d = wr_addr_q + 1'b1;
          if (wr_addr_q == {IN_BITS{1'b1}}) begin
            state_d     = SERVE;
            load_done_d = 1'b1;
          end
        end
      end
      SERVE: begin
        if (load_start) begin
          state_d   = LOAD;
          wr_addr_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign lookup = (state_q == SERVE) && M0_valid;

  // Storage array has no reset so it maps onto distributed RAM.
  always_ff @(posedge clk) begin
    if (rst && wr_fire) begin
      table_q[wr_addr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      m1_q       <= '0;
      m1_valid_q <= 1'b0;
    end else begin
      m1_valid_q <= lookup;
      if (lookup) begin
        m1_q <= table_q[M0];
      end
    end
  end

`ifdef LUT_CHECKSUM_EN
  logic [15:0] sum_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sum_q <= '0;
    end else if (load_start) begin
      sum_q <= '0;
    end else if (wr_fire) begin
      sum_q <= sum_q + {{(16-OUT_BITS){1'b0}}, wr_data};
    end
  end

  assign load_sum = sum_q;
`endif

  assign wr_ready  = (state_q == LOAD);
  assign table_ok  = (state_q == SERVE);
  assign load_done = load_done_q;
  assign M1        = m1_q;
  assign M1_valid  = m1_valid_q;

endmodule

// File: tb/tb_lut_table_loader.sv
// Directed bench for lut_table_loader: reset, full load, lookups, backpressure, restart, abort.
module tb_lut_table_loader;

  logic       clk;
  logic       rst;
  logic       load_start;
  logic       wr_valid;
  logic [1:0] wr_data;
  logic       wr_ready;
  logic       load_done;
  logic       table_ok;
  logic [7:0] M0;
  logic       M0_valid;
  logic [1:0] M1;
  logic       M1_valid;
`ifdef LUT_CHECKSUM_EN
  logic [15:0] load_sum;
`endif

  int ncmp  = 0;
  int nfail = 0;

  lut_table_loader #(.IN_BITS(8), .OUT_BITS(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .load_done  (load_done),
    .table_ok   (table_ok),
    .M0         (M0),
    .M0_valid   (M0_valid),
    .M1         (M1),
    .M1_valid   (M1_valid)
`ifdef LUT_CHECKSUM_EN
    ,
    .load_sum   (load_sum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic lookup(input logic [7:0] a, input logic [1:0] exp, input string tag);
    M0       = a;
    M0_valid = 1'b1;
    tick();
    M0_valid = 1'b0;
    chk({tag, "_m1"}, {30'd0, M1}, {30'd0, exp});
    chk({tag, "_m1v"}, {31'd0, M1_valid}, 32'd1);
  endtask

  initial begin
    int pulses;
    int idx;

    rst        = 1'b0;
    load_start = 1'b0;
    wr_valid   = 1'b0;
    wr_data    = 2'b00;
    M0         = 8'h00;
    M0_valid   = 1'b0;
    tick();
    tick();
    chk("rst_table_ok", {31'd0, table_ok}, 32'd0);
    chk("rst_wr_ready", {31'd0, wr_ready}, 32'd0);
    chk("rst_load_done", {31'd0, load_done}, 32'd0);
    chk("rst_m1", {30'd0, M1}, 32'd0);
    chk("rst_m1_valid", {31'd0, M1_valid}, 32'd0);
    rst = 1'b1;
    tick();

    // Full load, entry[a] = a[1:0]; load_done expected on the 257th cycle after load_start.
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    chk("full_wr_ready", {31'd0, wr_ready}, 32'd1);
    chk("full_table_ok_loading", {31'd0, table_ok}, 32'd0);
    pulses = 0;
    for (int a = 0; a < 256; a++) begin
      wr_valid = 1'b1;
      wr_data  = 2'(a);
      tick();
      if (load_done) pulses++;
    end
    wr_valid = 1'b0;
    chk("full_done_at_257", {31'd0, load_done}, 32'd1);
    chk("full_table_ok", {31'd0, table_ok}, 32'd1);
    chk("full_wr_ready_off", {31'd0, wr_ready}, 32'd0);
`ifdef LUT_CHECKSUM_EN
    chk("full_load_sum", {16'd0, load_sum}, 32'd384);
`endif
    tick();
    chk("full_done_one_cycle", {31'd0, load_done}, 32'd0);
    chk("full_done_pulses", pulses, 32'd1);
    chk("full_table_ok_hold", {31'd0, table_ok}, 32'd1);

    // Back-to-back lookups.
    M0_valid = 1'b1;
    M0 = 8'h00;
    tick();
    chk("lk00_m1", {30'd0, M1}, 32'd0);
    chk("lk00_m1v", {31'd0, M1_valid}, 32'd1);
    M0 = 8'h05;
    tick();
    chk("lk05_m1", {30'd0, M1}, 32'd1);
    chk("lk05_m1v", {31'd0, M1_valid}, 32'd1);
    M0 = 8'hFF;
    tick();
    chk("lkff_m1", {30'd0, M1}, 32'd3);
    chk("lkff_m1v", {31'd0, M1_valid}, 32'd1);
    M0_valid = 1'b0;
    M0 = 8'h00;
    tick();
    chk("idle_m1v", {31'd0, M1_valid}, 32'd0);
    chk("idle_m1_hold", {30'd0, M1}, 32'd3);

    // Writes outside LOAD are ignored.
    wr_valid = 1'b1;
    wr_data  = 2'b10;
    tick();
    tick();
    wr_valid = 1'b0;
    lookup(8'h03, 2'b11, "serve_wr_ignored");
    lookup(8'h00, 2'b00, "serve_wr_ignored0");

    // Backpressure: wr_valid every other cycle, entry[a] = ~a[1:0].
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    chk("bp_table_ok_drop", {31'd0, table_ok}, 32'd0);
    idx = 0;
    pulses = 0;
    for (int c = 0; c < 600 && idx < 256; c++) begin
      wr_valid = c[0];
      wr_data  = ~(2'(idx));
      tick();
      if (load_done) pulses++;
      if (wr_valid) idx++;
    end
    wr_valid = 1'b0;
    chk("bp_transfers", idx, 32'd256);
    chk("bp_done_after_last", {31'd0, load_done}, 32'd1);
    chk("bp_done_pulses", pulses, 32'd1);
`ifdef LUT_CHECKSUM_EN
    chk("bp_load_sum", {16'd0, load_sum}, 32'd384);
`endif
    lookup(8'h00, 2'b11, "bp_lk00");
    lookup(8'h06, 2'b01, "bp_lk06");
    lookup(8'h81, 2'b10, "bp_lk81");
    lookup(8'hFF, 2'b00, "bp_lkff");

    // Restart at entry 100, then full reload of 2'b10.
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    pulses = 0;
    for (int a = 0; a < 100; a++) begin
      wr_valid = 1'b1;
      wr_data  = 2'b01;
      tick();
      if (load_done) pulses++;
    end
    load_start = 1'b1;
    wr_data    = 2'b01;
    tick();
    load_start = 1'b0;
    chk("rs_still_loading", {31'd0, wr_ready}, 32'd1);
    for (int a = 0; a < 256; a++) begin
      wr_valid = 1'b1;
      wr_data  = 2'b10;
      tick();
      if (load_done) pulses++;
    end
    wr_valid = 1'b0;
    chk("rs_done_after_last", {31'd0, load_done}, 32'd1);
    chk("rs_done_pulses", pulses, 32'd1);
    lookup(8'h00, 2'b10, "rs_lk00");
    lookup(8'h63, 2'b10, "rs_lk63");
    lookup(8'hFF, 2'b10, "rs_lkff");

    // Lookup in SERVE coinciding with load_start is still honoured.
    M0         = 8'h10;
    M0_valid   = 1'b1;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    M0_valid   = 1'b0;
    chk("ls_lookup_m1", {30'd0, M1}, 32'd2);
    chk("ls_lookup_m1v", {31'd0, M1_valid}, 32'd1);
    chk("ls_table_ok_drop", {31'd0, table_ok}, 32'd0);
    chk("ls_wr_ready", {31'd0, wr_ready}, 32'd1);

    // Abort with a one-cycle reset at entry 50.
    pulses = 0;
    for (int a = 0; a < 50; a++) begin
      wr_valid = 1'b1;
      wr_data  = 2'b00;
      tick();
    end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("ab_table_ok", {31'd0, table_ok}, 32'd0);
    chk("ab_wr_ready", {31'd0, wr_ready}, 32'd0);
    chk("ab_load_done", {31'd0, load_done}, 32'd0);
    chk("ab_m1_cleared", {30'd0, M1}, 32'd0);
    for (int a = 0; a < 300; a++) begin
      wr_valid = 1'b1;
      tick();
      if (load_done) pulses++;
    end
    wr_valid = 1'b0;
    chk("ab_no_done", pulses, 32'd0);
    chk("ab_needs_start", {31'd0, wr_ready}, 32'd0);
    M0       = 8'h00;
    M0_valid = 1'b1;
    tick();
    M0_valid = 1'b0;
    chk("ab_m1v", {31'd0, M1_valid}, 32'd0);
    chk("ab_m1_hold", {30'd0, M1}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
